// File: rtl/counter_if.sv
// Handshake bundle between the PWM period timebase and its consumers.
// The master side programs the terminal count and enable; the slave side reports count and wrap pulse.
`timescale 1ns/1ps

interface counter_if #(
    parameter int unsigned WIDTH = 16
);
    logic             Enable;
    logic [WIDTH-1:0] MaxCount;
    logic             Done;
    logic [WIDTH-1:0] Count;

    modport master (
        output Enable,
        output MaxCount,
        input  Done,
        input  Count
    );

    modport slave (
        input  Enable,
        input  MaxCount,
        output Done,
        output Count
    );
endinterface : counter_if

// File: rtl/counter.sv
// Free-running modulo counter: counts 0..MaxCount while enabled, then wraps with a one-cycle Done pulse.
// Both outputs come straight from flops, so downstream compare logic sees no input-to-output path.
`timescale 1ns/1ps

module counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic      MClk,
    input  logic      nReset,
    counter_if.slave  bus
);
    logic [WIDTH-1:0] count_q;
    logic             done_q;
    logic             at_terminal;

    // ">=" rather than "==" so a terminal lowered below the running count forces an immediate wrap.
    assign at_terminal = (count_q >= bus.MaxCount);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge MClk or negedge nReset) begin
        if (!nReset) begin
            count_q <= '0;
            done_q  <= 1'b0;
        end else if (!bus.Enable) begin
            count_q <= '0;
            done_q  <= 1'b0;
        end else if (at_terminal) begin
            count_q <= '0;
            done_q  <= 1'b1;
        end else begin
            count_q <= count_q + 1'b1;
            done_q  <= 1'b0;
        end
    end

    assign bus.Count = count_q;
    assign bus.Done  = done_q;
endmodule : counter

// File: tb/tb_counter.sv
// Directed bench for the PWM period counter: reset, period length, enable gating, terminal changes, full range.
`timescale 1ns/1ps

module tb_counter;
    localparam int unsigned WIDTH = 16;

    logic MClk;
    logic nReset;
    int   vectors;
    int   miscompares;
    int   bad;

    counter_if #(.WIDTH(WIDTH)) bus ();

    counter #(.WIDTH(WIDTH)) dut (
        .MClk   (MClk),
        .nReset (nReset),
        .bus    (bus)
    );

    initial MClk = 1'b0;
    always #20 MClk = ~MClk;

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic edge_n(input int n);
        repeat (n) @(negedge MClk);
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        nReset       = 1'b0;
        bus.Enable   = 1'b0;
        bus.MaxCount = '0;

        #5;
        chk("reset_count", 32'(bus.Count), 0);
        chk("reset_done", 32'(bus.Done), 0);
        edge_n(1);
        nReset = 1'b1;

        // Basic period with MaxCount=500 from a cleared state.
        bus.MaxCount = 16'd500;
        bus.Enable   = 1'b1;
        bad = 0;
        for (int k = 1; k <= 500; k++) begin
            edge_n(1);
            if (bus.Count !== 16'(k) || bus.Done !== 1'b0) bad++;
        end
        chk("ramp_1_to_500", 32'(bad), 0);
        chk("ramp_end_count", 32'(bus.Count), 500);
        edge_n(1);
        chk("first_wrap_count", 32'(bus.Count), 0);
        chk("first_wrap_done", 32'(bus.Done), 1);
        for (int p = 0; p < 4; p++) begin
            bad = 0;
            for (int k = 1; k <= 500; k++) begin
                edge_n(1);
                if (bus.Count !== 16'(k) || bus.Done !== 1'b0) bad++;
            end
            chk("period_body", 32'(bad), 0);
            edge_n(1);
            chk("period_wrap_done", 32'(bus.Done), 1);
            chk("period_wrap_count", 32'(bus.Count), 0);
        end

        // Asynchronous reset mid-count at Count=37.
        edge_n(37);
        chk("pre_reset_count", 32'(bus.Count), 37);
        #5 nReset = 1'b0;
        #1;
        chk("async_reset_count", 32'(bus.Count), 0);
        chk("async_reset_done", 32'(bus.Done), 0);
        edge_n(1);
        nReset     = 1'b1;
        bus.Enable = 1'b0;

        // Enable gating with MaxCount=10.
        bus.MaxCount = 16'd10;
        bus.Enable   = 1'b1;
        edge_n(6);
        chk("gate_pre_count", 32'(bus.Count), 6);
        bus.Enable = 1'b0;
        for (int k = 0; k < 3; k++) begin
            edge_n(1);
            chk("gate_off_count", 32'(bus.Count), 0);
            chk("gate_off_done", 32'(bus.Done), 0);
        end
        bus.Enable = 1'b1;
        edge_n(1);
        chk("reenable_count", 32'(bus.Count), 1);
        bad = 0;
        for (int k = 2; k <= 10; k++) begin
            edge_n(1);
            if (bus.Count !== 16'(k) || bus.Done !== 1'b0) bad++;
        end
        chk("reenable_no_early_done", 32'(bad), 0);
        edge_n(1);
        chk("reenable_done_11th", 32'(bus.Done), 1);
        chk("reenable_wrap_count", 32'(bus.Count), 0);

        // Shrinking terminal: 100 -> 20 while at Count=50.
        bus.Enable = 1'b0;
        edge_n(1);
        bus.MaxCount = 16'd100;
        bus.Enable   = 1'b1;
        edge_n(50);
        chk("shrink_pre_count", 32'(bus.Count), 50);
        bus.MaxCount = 16'd20;
        edge_n(1);
        chk("shrink_wrap_count", 32'(bus.Count), 0);
        chk("shrink_wrap_done", 32'(bus.Done), 1);
        bad = 0;
        for (int k = 1; k <= 20; k++) begin
            edge_n(1);
            if (bus.Count !== 16'(k) || bus.Done !== 1'b0) bad++;
        end
        chk("shrink_period_body", 32'(bad), 0);
        edge_n(1);
        chk("shrink_period_done", 32'(bus.Done), 1);

        // Degenerate terminal MaxCount=0.
        bus.Enable = 1'b0;
        edge_n(1);
        chk("zero_cleared_done", 32'(bus.Done), 0);
        bus.MaxCount = '0;
        bus.Enable   = 1'b1;
        for (int k = 0; k < 5; k++) begin
            edge_n(1);
            chk("zero_term_count", 32'(bus.Count), 0);
            chk("zero_term_done", 32'(bus.Done), 1);
        end

        // Full range: MaxCount=65535, no intermediate wrap.
        bus.Enable = 1'b0;
        edge_n(1);
        bus.MaxCount = 16'hFFFF;
        bus.Enable   = 1'b1;
        bad = 0;
        for (int k = 1; k <= 65535; k++) begin
            edge_n(1);
            if (bus.Count !== 16'(k) || bus.Done !== 1'b0) bad++;
        end
        chk("full_range_body", 32'(bad), 0);
        chk("full_range_top", 32'(bus.Count), 65535);
        edge_n(1);
        chk("full_range_wrap_count", 32'(bus.Count), 0);
        chk("full_range_wrap_done", 32'(bus.Done), 1);
        edge_n(1);
        chk("full_range_restart_count", 32'(bus.Count), 1);
        chk("full_range_restart_done", 32'(bus.Done), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule : tb_counter
